// File: rtl/sonata_pkg.sv
// Shared Sonata system constants.
//
// Holds the system clock frequency, the derived switch-debounce sample
// period and the bit layout of the switch field on the GPIO input bus.
// Also provides a width helper for counters that may degenerate to a
// single state.
package sonata_pkg;

    // System clock and derived 1 ms switch sample period.
    localparam int unsigned SysClkFreq           = 40_000_000;
    localparam int unsigned SwDebounceTickCycles = SysClkFreq / 1000;

    // Switch field layout on the GPIO input bus.
    localparam int unsigned GpioSwWidth   = 16;
    localparam int unsigned GpioUserSwLsb = 0;
    localparam int unsigned GpioUserSwMsb = 7;
    localparam int unsigned GpioNavSwLsb  = 8;
    localparam int unsigned GpioNavSwMsb  = 12;
    localparam int unsigned GpioSelSwLsb  = 13;
    localparam int unsigned GpioSelSwMsb  = 15;

    // Packed view of the switch field, MSB first.
    typedef struct packed {
        logic [2:0] sel;
        logic [4:0] nav;
        logic [7:0] user;
    } gpio_sw_t;

    // Bits needed to count 0..n-1, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sonata_tick_gen.sv
// Free-running prescaler producing a one-cycle tick every TickCycles clocks.
//
// Ports:
//   clk_i   system clock
//   rst_i   asynchronous active-high reset (counter returns to 0)
//   tick_o  high for one cycle when the count reaches TickCycles-1
//
// With TickCycles = 1 the tick is high on every cycle.
module sonata_tick_gen
    import sonata_pkg::*;
#(
    parameter int unsigned TickCycles = SwDebounceTickCycles
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    localparam int unsigned CntW = cnt_width(TickCycles);
    localparam logic [CntW-1:0] CntLast = CntW'(TickCycles - 1);

    logic [CntW-1:0] count;

    assign tick_o = (count == CntLast);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count <= '0;
        end else if (tick_o) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/sonata_sw_debounce.sv
// Mechanical switch conditioner for the GPIO input bus.
//
// Every bit is synchronised with a two-flop pair, then debounced against a
// shared sample tick: a new level is accepted only after it has disagreed
// with the current debounced level on StableTicks consecutive ticks. Any
// return to the debounced level restarts the count. Accepted changes give a
// one-cycle rise/fall pulse aligned with the sw_o change, and set a sticky
// interrupt flag one cycle later.
//
// Ports:
//   clk_i     system clock
//   rst_i     asynchronous active-high reset
//   sw_raw_i  raw active-high switch levels (asynchronous to clk_i)
//   clear_i   one-cycle pulse clearing irq_o (a same-cycle set wins)
//   sw_o      debounced switch levels
//   rise_o    one-cycle pulse per bit on an accepted 0->1 change
//   fall_o    one-cycle pulse per bit on an accepted 1->0 change
//   irq_o     sticky: any accepted change since the last clear
module sonata_sw_debounce
    import sonata_pkg::*;
#(
    parameter int unsigned Width       = GpioSwWidth,
    parameter int unsigned TickCycles  = SwDebounceTickCycles,
    parameter int unsigned StableTicks = 5,
    parameter logic [Width-1:0] ResetVal = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] sw_raw_i,
    input  logic             clear_i,
    output logic [Width-1:0] sw_o,
    output logic [Width-1:0] rise_o,
    output logic [Width-1:0] fall_o,
    output logic             irq_o
);

    localparam int unsigned CntW = cnt_width(StableTicks + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(StableTicks - 1);

    // Two-flop synchroniser; sync_q2 is the only view of the raw inputs.
    logic [Width-1:0] sync_q1;
    logic [Width-1:0] sync_q2;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q1 <= ResetVal;
            sync_q2 <= ResetVal;
        end else begin
            sync_q1 <= sw_raw_i;
            sync_q2 <= sync_q1;
        end
    end

    logic tick;

    sonata_tick_gen #(
        .TickCycles(TickCycles)
    ) u_tick_gen (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .tick_o(tick)
    );

    logic [Width-1:0] differs;
    logic [Width-1:0] accept;
    logic [CntW-1:0]  cnt [Width];

    for (genvar gi = 0; gi < Width; gi++) begin : g_bit
        assign differs[gi] = sync_q2[gi] ^ sw_o[gi];
        // The last required tick of a disagreement run commits the change.
        assign accept[gi]  = differs[gi] & tick & (cnt[gi] == CntLast);

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                cnt[gi] <= '0;
            end else if (!differs[gi]) begin
                cnt[gi] <= '0;
            end else if (tick) begin
                cnt[gi] <= accept[gi] ? '0 : cnt[gi] + 1'b1;
            end
        end
    end

    // Pulses are registered alongside sw_o so they coincide with the change.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sw_o   <= ResetVal;
            rise_o <= '0;
            fall_o <= '0;
            irq_o  <= 1'b0;
        end else begin
            sw_o   <= sw_o ^ accept;
            rise_o <= accept & sync_q2;
            fall_o <= accept & ~sync_q2;
            if (|(rise_o | fall_o)) begin
                irq_o <= 1'b1;
            end else if (clear_i) begin
                irq_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sonata_sw_debounce.sv
// Bench for sonata_sw_debounce: two instances (ResetVal 0 and 16'h0004)
// share all stimulus; a cycle model of the specified behaviour predicts
// every output of both, and directed scenarios add literal expectations.
module tb_sonata_sw_debounce;

    localparam int W = 16;
    localparam int T = 4;
    localparam int S = 3;
    localparam logic [W-1:0] RV_A = 16'h0000;
    localparam logic [W-1:0] RV_B = 16'h0004;

    logic clk = 1'b0;
    logic rst;
    logic clear;
    logic [W-1:0] raw;

    logic [W-1:0] sw_a, rise_a, fall_a;
    logic         irq_a;
    logic [W-1:0] sw_b, rise_b, fall_b;
    logic         irq_b;

    always #5 clk = ~clk;

    sonata_sw_debounce #(
        .Width(W), .TickCycles(T), .StableTicks(S), .ResetVal(RV_A)
    ) dut_a (
        .clk_i(clk), .rst_i(rst), .sw_raw_i(raw), .clear_i(clear),
        .sw_o(sw_a), .rise_o(rise_a), .fall_o(fall_a), .irq_o(irq_a)
    );

    sonata_sw_debounce #(
        .Width(W), .TickCycles(T), .StableTicks(S), .ResetVal(RV_B)
    ) dut_b (
        .clk_i(clk), .rst_i(rst), .sw_raw_i(raw), .clear_i(clear),
        .sw_o(sw_b), .rise_o(rise_b), .fall_o(fall_b), .irq_o(irq_b)
    );

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Raw input seen two clocks late; a tick every T-th clock since reset;
    // a level is accepted on the S-th tick of an unbroken disagreement with
    // the debounced level. The interrupt follows the pulses one clock later.
    logic [W-1:0] m_s1   [2];
    logic [W-1:0] m_s2   [2];
    logic [W-1:0] m_sw   [2];
    logic [W-1:0] m_rise [2];
    logic [W-1:0] m_fall [2];
    logic         m_irq  [2];
    int           m_run  [2][W];
    int           m_clocks = 0;

    function automatic logic [W-1:0] rv_of(input int m);
        return (m == 0) ? RV_A : RV_B;
    endfunction

    always @(posedge clk) begin
        bit tick;
        tick = ((m_clocks % T) == T - 1);
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                m_s1[m] = rv_of(m); m_s2[m] = rv_of(m); m_sw[m] = rv_of(m);
                m_rise[m] = '0; m_fall[m] = '0; m_irq[m] = 1'b0;
                for (int b = 0; b < W; b++) m_run[m][b] = 0;
            end else begin
                logic [W-1:0] nr, nf;
                if ((m_rise[m] | m_fall[m]) != '0) m_irq[m] = 1'b1;
                else if (clear) m_irq[m] = 1'b0;
                nr = '0; nf = '0;
                for (int b = 0; b < W; b++) begin
                    if (m_s2[m][b] == m_sw[m][b]) begin
                        m_run[m][b] = 0;
                    end else if (tick) begin
                        m_run[m][b] = m_run[m][b] + 1;
                        if (m_run[m][b] == S) begin
                            m_run[m][b] = 0;
                            m_sw[m][b] = m_s2[m][b];
                            if (m_s2[m][b]) nr[b] = 1'b1; else nf[b] = 1'b1;
                        end
                    end
                end
                m_rise[m] = nr; m_fall[m] = nf;
                m_s2[m] = m_s1[m];
                m_s1[m] = raw;
            end
        end
        m_clocks = rst ? 0 : m_clocks + 1;
    end

    bit cmp_on = 1'b0;

    always @(negedge clk) begin
        if (cmp_on) begin
            check("a_sw",   sw_a,   m_sw[0]);
            check("a_rise", rise_a, m_rise[0]);
            check("a_fall", fall_a, m_fall[0]);
            check("a_irq",  irq_a,  m_irq[0]);
            check("b_sw",   sw_b,   m_sw[1]);
            check("b_rise", rise_b, m_rise[1]);
            check("b_fall", fall_b, m_fall[1]);
            check("b_irq",  irq_b,  m_irq[1]);
        end
    end

    // Inputs change just after the falling edge, after the compare process.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    int n;
    int pulses;

    initial begin
        rst = 1'b1; raw = '0; clear = 1'b0;
        step();
        cmp_on = 1'b1;
        check("reset_sw_b", sw_b, 32'h0004);
        step(); step();
        rst = 1'b0;

        // 1: quiet input after reset.
        pulses = 0;
        repeat (100) begin
            step();
            if ((rise_a | fall_a) != '0 || irq_a) pulses++;
        end
        check("t1_sw", sw_a, 32'h0);
        check("t1_activity", pulses, 0);

        // 2: single clean rise on bit 3.
        raw[3] = 1'b1;
        n = 0;
        while (!sw_a[3] && n < 40) begin step(); n++; end
        check("t2_latency_ok", (n >= 11 && n <= 14), 1);
        check("t2_rise_coincident", rise_a[3], 1);
        step();
        check("t2_rise_one_cycle", rise_a[3], 0);
        check("t2_irq", irq_a, 1);

        // 3: bit 7 bouncing faster than the debounce window.
        clear = 1'b1; step(); clear = 1'b0; step();
        check("t3_irq_cleared", irq_a, 0);
        pulses = 0;
        for (int i = 0; i < 200; i++) begin
            if (i % 5 == 0) raw[7] = ~raw[7];
            step();
            if (rise_a[7] || fall_a[7] || irq_a) pulses++;
        end
        raw[7] = 1'b0;
        check("t3_sw7", sw_a[7], 0);
        check("t3_activity", pulses, 0);

        // 4: all bits together.
        raw = '0;
        repeat (30) step();
        raw = 16'hFFFF;
        n = 0;
        while (rise_a == '0 && n < 20) begin step(); n++; end
        check("t4_rise_all", rise_a, 32'hFFFF);
        check("t4_sw_all", sw_a, 32'hFFFF);
        step();
        check("t4_rise_done", rise_a, 32'h0);
        raw = '0;
        n = 0;
        while (fall_a == '0 && n < 20) begin step(); n++; end
        check("t4_fall_all", fall_a, 32'hFFFF);
        step();
        check("t4_fall_done", fall_a, 32'h0);

        // 5: clear coinciding with a pulse loses; a lone clear wins.
        raw[0] = 1'b1;
        n = 0;
        while (!rise_a[0] && n < 20) begin step(); n++; end
        check("t5_pulse_seen", rise_a[0], 1);
        clear = 1'b1; step(); clear = 1'b0;
        check("t5_set_wins", irq_a, 1);
        repeat (3) step();
        clear = 1'b1; step(); clear = 1'b0;
        check("t5_clear", irq_a, 0);

        // 6: reset in the middle of a debounce run.
        raw[2] = 1'b1;
        repeat (10) step();
        rst = 1'b1;
        pulses = 0;
        repeat (3) begin
            step();
            if ((rise_a | fall_a | rise_b | fall_b) != '0) pulses++;
        end
        check("t6_no_pulse_in_reset", pulses, 0);
        check("t6_sw_b_reset", sw_b, 32'h0004);
        rst = 1'b0;
        n = 0; pulses = 0;
        while (!sw_a[2] && n < 40) begin
            step(); n++;
            if (rise_b[2]) pulses++;
        end
        check("t6_latency_ok", (n >= 11 && n <= 14), 1);
        check("t6_rise2", rise_a[2], 1);
        repeat (10) begin step(); if (rise_b[2] || fall_b[2]) pulses++; end
        check("t6_b_no_pulse", pulses, 0);

        // Random stimulus: sparse flips, short bounce bursts, clears, resets.
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(7) == 0) raw[$urandom_range(W-1)] ^= 1'b1;
            if ($urandom_range(49) == 0) begin
                int b;
                b = $urandom_range(W-1);
                for (int j = 0; j < 6; j++) begin
                    raw[b] ^= 1'b1;
                    step();
                end
            end
            clear = ($urandom_range(19) == 0);
            rst = ($urandom_range(599) == 0);
            step();
        end
        clear = 1'b0; rst = 1'b0;
        repeat (20) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
